// File: rtl/afifo_axi_wr_tx.sv
// afifo_axi_wr_tx
// Write-clock-domain transmitter feeding a 4-entry async FIFO toward the MIG
// domain. It accepts one AXI write burst at a time and serializes it into
// FIFO words: a command word, then awlen+1 data words. A posted B response is
// returned after the last data word has been pushed.
//
// Ports:
//   wclk, wrst_n             write clock, async active-low reset
//   awvalid/awready/awid/awaddr/awlen   AW channel
//   wvalid/wready/wdata/wstrb/wlast     W channel
//   bvalid/bready/bid/bresp             B channel (OKAY / SLVERR)
//   afifo_wen/afifo_wdata/afifo_wqfull  FIFO write side
//   burst_cnt                completed bursts, wraps
//
// Word layout:
//   cmd : [41]=1 [40]=0        [39:32]=awlen  [31:0]=awaddr
//   data: [41]=0 [40]=gen_last [39:36]=0 [35:32]=wstrb [31:0]=wdata
module afifo_axi_wr_tx #(
  parameter int AFIFODW = 42,
  parameter int IDW     = 4
) (
  input  logic               wclk,
  input  logic               wrst_n,
  input  logic               awvalid,
  output logic               awready,
  input  logic [IDW-1:0]     awid,
  input  logic [31:0]        awaddr,
  input  logic [7:0]         awlen,
  input  logic               wvalid,
  output logic               wready,
  input  logic [31:0]        wdata,
  input  logic [3:0]         wstrb,
  input  logic               wlast,
  output logic               bvalid,
  input  logic               bready,
  output logic [IDW-1:0]     bid,
  output logic [1:0]         bresp,
  output logic               afifo_wen,
  output logic [AFIFODW-1:0] afifo_wdata,
  input  logic               afifo_wqfull,
  output logic [15:0]        burst_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]     r_state;
  logic           r_awready;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_addr;
  logic [7:0]     r_len;
  logic [7:0]     r_beat;
  logic           r_err;
  logic [15:0]    r_burst_cnt;

  logic w_gen_last;
  logic w_push_cmd;
  logic w_push_data;

  // The beat counter, not the master's wlast, decides where the burst ends.
  assign w_gen_last  = (r_beat == r_len);
  assign w_push_cmd  = (r_state == S_CMD) & ~afifo_wqfull;
  assign wready      = (r_state == S_DATA) & ~afifo_wqfull;
  assign w_push_data = wready & wvalid;

  // awready is registered so it reads 0 while reset is held and rises on the
  // first clock in IDLE (or directly on the B handshake edge).
  assign awready   = r_awready;
  assign bvalid    = (r_state == S_RESP);
  assign bid       = bvalid ? r_id : '0;
  assign bresp     = {bvalid & r_err, 1'b0};
  assign burst_cnt = r_burst_cnt;
  assign afifo_wen = w_push_cmd | w_push_data;

  always_comb begin
    afifo_wdata = '0;
    case (r_state)
      S_CMD:   afifo_wdata = {1'b1, 1'b0, r_len, r_addr};
      S_DATA:  afifo_wdata = {1'b0, w_gen_last, 4'b0000, wstrb, wdata};
      default: afifo_wdata = '0;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state     <= S_IDLE;
      r_awready   <= 1'b0;
      r_id        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_err       <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_awready) begin
            r_awready <= 1'b1;
          end else if (awvalid) begin
            r_id      <= awid;
            r_addr    <= awaddr;
            r_len     <= awlen;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_awready <= 1'b0;
            r_state   <= S_CMD;
          end
        end
        S_CMD: begin
          if (!afifo_wqfull) r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_push_data) begin
            // Wraps to 0 only on the awlen=255 final beat, as we leave DATA.
            r_beat <= r_beat + 8'd1;
            if (wlast != w_gen_last) r_err <= 1'b1;
            if (w_gen_last) r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (bready) begin
            r_state     <= S_IDLE;
            r_awready   <= 1'b1;
            r_burst_cnt <= r_burst_cnt + 16'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_axi_wr_tx.sv
module tb_afifo_axi_wr_tx;

  logic        wclk, wrst_n;
  logic        awvalid, awready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        afifo_wen;
  logic [41:0] afifo_wdata;
  logic        afifo_wqfull;
  logic [15:0] burst_cnt;

  afifo_axi_wr_tx #(.AFIFODW(42), .IDW(4)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .afifo_wen(afifo_wen), .afifo_wdata(afifo_wdata), .afifo_wqfull(afifo_wqfull),
    .burst_cnt(burst_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_bc = 16'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Push monitor: records every FIFO write with the cycle it happened in.
  logic [41:0] pq_word[$];
  int          pq_cyc[$];
  always @(negedge wclk) begin
    if (wrst_n && afifo_wen) begin
      chk("wen_while_full", {63'd0, afifo_wqfull}, 64'd0);
      pq_word.push_back(afifo_wdata);
      pq_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic [7:0]  len;
    logic [31:0] addr;
    logic [3:0]  id;
    int          wl_at;       // beat on which the master raises wlast
    int          stall_cmd;   // cycles of wqfull at the start of CMD
    int          stall_beat;  // beat index that sees one cycle of wqfull
    int          bhold;       // cycles bready is held low with bvalid up
    logic [1:0]  resp;
  } vec_t;

  vec_t tv[5];

  function automatic logic [31:0] data_of(input vec_t v, input int i);
    return 32'hDEADBEEF + (v.addr - 32'h1000) + i;
  endfunction

  function automatic logic [3:0] strb_of(input int i);
    logic [3:0] s;
    s = i[3:0];
    return 4'hF - s;
  endfunction

  task automatic set_beat(input vec_t v, input int b);
    wdata = data_of(v, b);
    wstrb = strb_of(b);
    wlast = (b == v.wl_at);
  endtask

  task automatic aw_handshake(input vec_t v, output int h);
    int g;
    @(posedge wclk); #1;
    awid = v.id; awaddr = v.addr; awlen = v.len; awvalid = 1'b1;
    g = 0;
    @(negedge wclk);
    while (!awready && g < 20) begin @(negedge wclk); g++; end
    if (!awready) chk("aw_timeout", 64'd0, 64'd1);
    h = cyc;
    @(posedge wclk); #1;
    awvalid = 1'b0;
  endtask

  task automatic run_burst(input vec_t v);
    int h, b, g, stalled, lastc, sz, bad;
    bit first;
    logic [41:0] ew;
    pq_word.delete(); pq_cyc.delete();
    aw_handshake(v, h);
    wvalid = 1'b1; b = 0; set_beat(v, b);
    // W is offered from the CMD cycle on; it must not be taken before DATA.
    if (v.stall_cmd > 0) afifo_wqfull = 1'b1;
    repeat (v.stall_cmd) begin @(posedge wclk); #1; end
    afifo_wqfull = 1'b0;
    stalled = 0; g = 0; first = 1'b1;
    while (b <= int'(v.len) && g < 2000) begin
      if (b == v.stall_beat && stalled == 0) begin afifo_wqfull = 1'b1; stalled = 1; end
      else afifo_wqfull = 1'b0;
      @(negedge wclk);
      if (first) begin
        chk("wready_in_cmd", {63'd0, wready}, 64'd0);
        chk("awready_in_cmd", {63'd0, awready}, 64'd0);
        first = 1'b0;
      end
      if (wready && wvalid) begin @(posedge wclk); #1; b++; set_beat(v, b); end
      else begin @(posedge wclk); #1; end
      g++;
    end
    wvalid = 1'b0; afifo_wqfull = 1'b0;
    if (g >= 2000) chk("w_timeout", 64'd0, 64'd1);
    sz = pq_word.size();
    chk("push_count", 64'(sz), 64'(int'(v.len) + 2));
    if (sz > 0) begin
      ew = {2'b10, v.len, v.addr};
      chk("cmd_word", {22'd0, pq_word[0]}, {22'd0, ew});
      if (v.stall_cmd == 0) chk("cmd_latency", 64'(pq_cyc[0]), 64'(h + 1));
    end
    if (sz > 1) chk("data_latency", {63'd0, pq_cyc[1] >= h + 2}, 64'd1);
    for (int i = 0; i <= int'(v.len); i++) begin
      if (i + 1 < sz) begin
        ew = {1'b0, i == int'(v.len), 4'b0000, strb_of(i), data_of(v, i)};
        chk("data_word", {22'd0, pq_word[i+1]}, {22'd0, ew});
      end
    end
    lastc = (sz > 0) ? pq_cyc[sz-1] : 0;
    g = 0;
    @(negedge wclk);
    while (!bvalid && g < 20) begin @(negedge wclk); g++; end
    chk("bvalid_latency", 64'(cyc), 64'(lastc + 1));
    chk("bid", {60'd0, bid}, {60'd0, v.id});
    chk("bresp", {62'd0, bresp}, {62'd0, v.resp});
    if (v.bhold > 0) begin
      awvalid = 1'b1; bad = 0;
      repeat (v.bhold) begin
        @(negedge wclk);
        if (!bvalid || bid != v.id || bresp != v.resp || awready) bad++;
      end
      chk("b_hold_stable", 64'(bad), 64'd0);
    end
    bready = 1'b1;
    @(posedge wclk); #1;
    bready = 1'b0; awvalid = 1'b0;
    exp_bc = exp_bc + 16'd1;
    @(negedge wclk);
    chk("awready_after_b", {63'd0, awready}, 64'd1);
    chk("bvalid_clear", {63'd0, bvalid}, 64'd0);
    chk("burst_cnt", {48'd0, burst_cnt}, {48'd0, exp_bc});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g, b, h;
    vec_t rv;
    tv[0] = '{8'd0, 32'h0000_1000, 4'd1, 0, 0, 99999, 0,  2'b00};
    tv[1] = '{8'd3, 32'h0000_2000, 4'd2, 3, 2, 2,     0,  2'b00};
    tv[2] = '{8'd3, 32'h0000_3000, 4'd5, 2, 0, 99999, 0,  2'b10};
    tv[3] = '{8'd1, 32'h0000_4000, 4'd7, 1, 0, 99999, 10, 2'b00};
    tv[4] = '{8'd7, 32'h0000_5000, 4'd3, 7, 1, 5,     0,  2'b00};

    wrst_n = 1'b0; awvalid = 1'b0; awid = '0; awaddr = '0; awlen = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    afifo_wqfull = 1'b0;
    #12;
    chk("rst_ctl", {40'd0, awready, wready, bvalid, bid, bresp, afifo_wen, burst_cnt}, 64'd0);
    chk("rst_wdata", {22'd0, afifo_wdata}, 64'd0);
    @(negedge wclk); wrst_n = 1'b1;
    @(negedge wclk);
    chk("awready_after_rst", {63'd0, awready}, 64'd1);

    for (int i = 0; i < 5; i++) run_burst(tv[i]);

    // Reset in the middle of DATA, with beat 2 of 4 on the bus.
    rv = '{8'd3, 32'h0000_6000, 4'd9, 3, 0, 99999, 0, 2'b00};
    aw_handshake(rv, h);
    wvalid = 1'b1; b = 0; set_beat(rv, b); g = 0;
    while (b < 2 && g < 50) begin
      @(negedge wclk);
      if (wready) begin @(posedge wclk); #1; b++; set_beat(rv, b); end
      else begin @(posedge wclk); #1; end
      g++;
    end
    wrst_n = 1'b0;
    #1;
    chk("midrst_ctl", {40'd0, awready, wready, bvalid, bid, bresp, afifo_wen, burst_cnt}, 64'd0);
    chk("midrst_wdata", {22'd0, afifo_wdata}, 64'd0);
    wvalid = 1'b0;
    exp_bc = 16'd0;
    @(negedge wclk); wrst_n = 1'b1;
    @(negedge wclk);
    chk("awready_after_midrst", {63'd0, awready}, 64'd1);
    run_burst(tv[0]);

    // Back-to-back single-beat bursts, then preload the counter near the top
    // so the wrap is reached without 64K bursts.
    repeat (3) run_burst(tv[0]);
    @(negedge wclk);
    force dut.r_burst_cnt = 16'hFFFE;
    #1;
    release dut.r_burst_cnt;
    exp_bc = 16'hFFFE;
    run_burst(tv[0]);
    run_burst(tv[0]);
    chk("burst_cnt_wrapped", {48'd0, burst_cnt}, 64'd0);

    // Longest burst: 1 command + 256 data words.
    rv = '{8'd255, 32'h0000_7000, 4'd12, 255, 0, 99999, 0, 2'b00};
    run_burst(rv);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
